// File: rtl/mac_pkg.sv
// Shared definitions for the MAC operand staging path: operand width,
// operand type and the lane-skew supervisor state encoding.
package mac_pkg;

   localparam int DATA_W = 16;

   typedef logic [DATA_W-1:0] mac_operand_t;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      SKEW = 2'd1,
      ERR  = 2'd2
   } skew_state_e;

endpackage

// File: rtl/mac_lane_fifo.sv
// Single-lane operand FIFO. Fully synchronous, with a synchronous clear.
// The head entry is always visible on data_out. Pointers carry one extra
// wrap bit so that full and empty can be told apart.
module mac_lane_fifo #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              full,
   output logic              empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [AW:0]       wr_ptr_r;
   logic [AW:0]       rd_ptr_r;
   logic              do_push_s;
   logic              do_pop_s;

   assign empty    = (wr_ptr_r == rd_ptr_r);
   assign full     = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign data_out = mem_r[rd_ptr_r[AW-1:0]];

   // Ignore pushes into a full lane and pops from an empty one
   always_comb begin
      do_push_s = push && !full;
      do_pop_s  = pop && !empty;
   end

   // Read/write pointer advance; clear empties the lane
   always_ff @(posedge clk) begin
      if (clear) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + (AW+1)'(1'b1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + (AW+1)'(1'b1);
         end
      end
   end

   // Operand storage; contents need no reset since pointers gate visibility
   always_ff @(posedge clk) begin
      if (do_push_s && !clear) begin
         mem_r[wr_ptr_r[AW-1:0]] <= data_in;
      end
   end

endmodule

// File: rtl/mac_operand_pairer.sv
// Pairs the independently handshaked A and B operand streams for the MAC.
// Each lane is buffered in its own FIFO; a pair is issued only when both
// lanes hold data, so valid_a and valid_b always rise and fall together.
// Also counts issued pairs and supervises sustained lane skew.
module mac_operand_pairer #(
   parameter int DATA_W     = mac_pkg::DATA_W,
   parameter int DEPTH      = 4,
   parameter int SKEW_LIMIT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_a,
   input  logic              in_a_valid,
   output logic              in_a_ready,
   input  logic [DATA_W-1:0] in_b,
   input  logic              in_b_valid,
   output logic              in_b_ready,
   input  logic              hold,
   input  logic              flush,
   output logic [DATA_W-1:0] a,
   output logic [DATA_W-1:0] b,
   output logic              valid_a,
   output logic              valid_b,
   output logic [15:0]       pair_cnt,
   output logic              skew_err
);

   import mac_pkg::*;

   localparam int CW = $clog2(SKEW_LIMIT + 1);

   logic [DATA_W-1:0] head_a_s;
   logic [DATA_W-1:0] head_b_s;
   logic              full_a_s;
   logic              empty_a_s;
   logic              full_b_s;
   logic              empty_b_s;
   logic              push_a_s;
   logic              push_b_s;
   logic              issue_s;
   logic              clear_s;
   logic              skew_cond_s;

   logic [DATA_W-1:0] a_r;
   logic [DATA_W-1:0] b_r;
   logic              valid_r;
   logic [15:0]       pair_cnt_r;
   logic              skew_err_r;

   skew_state_e       state_r;
   skew_state_e       next_state_s;
   logic [CW-1:0]     skew_cnt_r;
   logic [CW-1:0]     next_cnt_s;

   // Ready depends only on registered fullness and reset, never on this cycle's pop
   assign in_a_ready = !full_a_s && !rst;
   assign in_b_ready = !full_b_s && !rst;

   assign a        = a_r;
   assign b        = b_r;
   assign valid_a  = valid_r;
   assign valid_b  = valid_r;
   assign pair_cnt = pair_cnt_r;
   assign skew_err = skew_err_r;

   // Handshake, issue and skew-condition decode; flush beats push and issue
   always_comb begin
      push_a_s    = in_a_valid && in_a_ready && !flush;
      push_b_s    = in_b_valid && in_b_ready && !flush;
      issue_s     = !empty_a_s && !empty_b_s && !hold && !flush;
      clear_s     = rst || flush;
      skew_cond_s = (full_a_s && empty_b_s) || (full_b_s && empty_a_s);
   end

   mac_lane_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo_a (
      .clk      (clk),
      .clear    (clear_s),
      .push     (push_a_s),
      .pop      (issue_s),
      .data_in  (in_a),
      .data_out (head_a_s),
      .full     (full_a_s),
      .empty    (empty_a_s)
   );

   mac_lane_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo_b (
      .clk      (clk),
      .clear    (clear_s),
      .push     (push_b_s),
      .pop      (issue_s),
      .data_in  (in_b),
      .data_out (head_b_s),
      .full     (full_b_s),
      .empty    (empty_b_s)
   );

   // Output pair registers; data holds its last value when no pair issues
   always_ff @(posedge clk) begin
      if (rst) begin
         a_r     <= '0;
         b_r     <= '0;
         valid_r <= 1'b0;
      end else if (issue_s) begin
         a_r     <= head_a_s;
         b_r     <= head_b_s;
         valid_r <= 1'b1;
      end else begin
         valid_r <= 1'b0;
      end
   end

   // Issued-pair counter, wraps naturally at 16 bits
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         pair_cnt_r <= 16'd0;
      end else if (issue_s) begin
         pair_cnt_r <= pair_cnt_r + 16'd1;
      end
   end

   // Skew supervisor state, dwell counter and sticky error flag
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state_r    <= RUN;
         skew_cnt_r <= '0;
         skew_err_r <= 1'b0;
      end else begin
         state_r    <= next_state_s;
         skew_cnt_r <= next_cnt_s;
         skew_err_r <= (next_state_s == ERR);
      end
   end

   // Skew supervisor next state: count consecutive skewed cycles up to the limit
   always_comb begin
      next_state_s = state_r;
      next_cnt_s   = skew_cnt_r;
      case (state_r)
         RUN: begin
            if (skew_cond_s) begin
               if (SKEW_LIMIT <= 1) begin
                  next_state_s = ERR;
                  next_cnt_s   = '0;
               end else begin
                  next_state_s = SKEW;
                  next_cnt_s   = CW'(1'b1);
               end
            end else begin
               next_state_s = RUN;
               next_cnt_s   = '0;
            end
         end
         SKEW: begin
            if (!skew_cond_s) begin
               next_state_s = RUN;
               next_cnt_s   = '0;
            end else if (skew_cnt_r == CW'(SKEW_LIMIT - 1)) begin
               next_state_s = ERR;
               next_cnt_s   = '0;
            end else begin
               next_state_s = SKEW;
               next_cnt_s   = skew_cnt_r + CW'(1'b1);
            end
         end
         ERR: begin
            next_state_s = ERR;
            next_cnt_s   = '0;
         end
         default: begin
            next_state_s = RUN;
            next_cnt_s   = '0;
         end
      endcase
   end

endmodule
